// File: rtl/pico_pkg.sv
// pico_pkg: shared constants and types for the pico MIPS fetch path.
//   OPC_W        opcode field width (opcode sits in the top OPC_W bits of a word)
//   OPC_*        opcode encodings; OPC_HALT stops the sequencer
//   seq_state_t  pc_sequencer FSM state encoding
package pico_pkg;

  localparam int OPC_W = 6;

  localparam logic [OPC_W-1:0] OPC_NOP  = 6'h00;
  localparam logic [OPC_W-1:0] OPC_ADD  = 6'h01;
  localparam logic [OPC_W-1:0] OPC_ADDI = 6'h02;
  localparam logic [OPC_W-1:0] OPC_BEQ  = 6'h08;
  localparam logic [OPC_W-1:0] OPC_JMP  = 6'h10;
  localparam logic [OPC_W-1:0] OPC_HALT = 6'h3F;

  typedef enum logic [1:0] {IDLE, RUN, HALT} seq_state_t;

endpackage

// File: rtl/pc_next_calc.sv
// pc_next_calc: combinational next-PC selection for pc_sequencer.
// Optional feature macro: PC_LINK_EN (adds call/ret/link inputs).
// Ports:
//   pc             in   current PC
//   hold           in   keep PC unchanged (stall or halt opcode this cycle)
//   ret/call/link  in   return / call request and link register (PC_LINK_EN only)
//   jump,jump_addr in   absolute jump request and target
//   branch,
//   branch_offset  in   relative branch request and signed offset
//   pc_next        out  selected next PC; all arithmetic wraps modulo 2**AddrSz
module pc_next_calc #(
  parameter int AddrSz = 6
) (
  input  logic [AddrSz-1:0] pc,
  input  logic              hold,
`ifdef PC_LINK_EN
  input  logic              call,
  input  logic              ret,
  input  logic [AddrSz-1:0] link,
`endif
  input  logic              jump,
  input  logic [AddrSz-1:0] jump_addr,
  input  logic              branch,
  input  logic [AddrSz-1:0] branch_offset,
  output logic [AddrSz-1:0] pc_next
);

  always_comb begin
    // Plain AddrSz-bit additions: the carry out is dropped, giving the
    // required wrap in both directions (a negative offset is two's complement).
    pc_next = pc + AddrSz'(1);
    if (hold) begin
      pc_next = pc;
`ifdef PC_LINK_EN
    end else if (ret) begin
      pc_next = link;
    end else if (call) begin
      pc_next = jump_addr;
`endif
    end else if (jump) begin
      pc_next = jump_addr;
    end else if (branch) begin
      pc_next = pc + branch_offset;
    end
  end

endmodule

// File: rtl/pc_sequencer.sv
// pc_sequencer: program-counter sequencer for the pico MIPS core.
// Optional feature macro: PC_LINK_EN (single-entry call/return link register).
// Ports:
//   clk, reset     in   clock (rising edge), asynchronous active-high reset
//   start          in   leave IDLE and begin fetching at PC=0
//   stall          in   hold PC and state this cycle
//   branch         in   relative branch by branch_offset (signed)
//   jump           in   absolute jump to jump_addr
//   call, ret      in   (PC_LINK_EN) call to jump_addr saving PC+1 / return to link
//   instruction    in   program_memory word at `address` (combinational read)
//   address        out  current PC
//   instr          out  instruction forwarded to decoder, zero when not valid
//   instr_valid    out  high in RUN while stall=0
//   halted         out  high in HALT
module pc_sequencer
  import pico_pkg::*;
#(
  parameter int AddrSz        = 6,
  parameter int InstructionSz = 24
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     start,
  input  logic                     stall,
  input  logic                     branch,
  input  logic [AddrSz-1:0]        branch_offset,
  input  logic                     jump,
  input  logic [AddrSz-1:0]        jump_addr,
`ifdef PC_LINK_EN
  input  logic                     call,
  input  logic                     ret,
`endif
  input  logic [InstructionSz-1:0] instruction,
  output logic [AddrSz-1:0]        address,
  output logic [InstructionSz-1:0] instr,
  output logic                     instr_valid,
  output logic                     halted
);

  seq_state_t        state_reg, state_next;
  logic [AddrSz-1:0] pc_reg, pc_next;
  logic [OPC_W-1:0]  opcode;
  logic              is_halt;

  assign opcode  = instruction[InstructionSz-1 -: OPC_W];
  // A halt opcode only counts on a cycle the decoder actually consumes it.
  assign is_halt = (opcode == OPC_HALT) && !stall;

`ifdef PC_LINK_EN
  logic [AddrSz-1:0] link_reg;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      link_reg <= '0;
    end else if (state_reg == RUN && !stall && !is_halt && !ret && call) begin
      link_reg <= pc_reg + AddrSz'(1);
    end
  end
`endif

  pc_next_calc #(.AddrSz(AddrSz)) u_next (
    .pc            (pc_reg),
    .hold          (stall || is_halt),
`ifdef PC_LINK_EN
    .call          (call),
    .ret           (ret),
    .link          (link_reg),
`endif
    .jump          (jump),
    .jump_addr     (jump_addr),
    .branch        (branch),
    .branch_offset (branch_offset),
    .pc_next       (pc_next)
  );

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_reg <= IDLE;
      pc_reg    <= '0;
    end else begin
      state_reg <= state_next;
      // PC only moves in RUN; IDLE keeps it at 0 and HALT freezes it.
      if (state_reg == RUN) begin
        pc_reg <= pc_next;
      end
    end
  end

  always_comb begin
    state_next  = state_reg;
    instr_valid = 1'b0;
    halted      = 1'b0;
    case (state_reg)
      IDLE: begin
        if (start) state_next = RUN;
      end
      RUN: begin
        instr_valid = !stall;
        if (is_halt) state_next = HALT;
      end
      HALT: begin
        halted = 1'b1;
      end
      default: state_next = IDLE;
    endcase
  end

  assign address = pc_reg;
  assign instr   = instr_valid ? instruction : '0;

endmodule

// File: tb/tb_pc_sequencer.sv
// tb_pc_sequencer: scoreboard bench for pc_sequencer (AddrSz=6, InstructionSz=24).
// Stimulus pushes the expected fetch (address, word) for every cycle it expects
// instr_valid; a negedge monitor pops and compares whenever instr_valid is high.
// Build with PC_LINK_EN defined to also exercise call/ret.
module tb_pc_sequencer;
  localparam int AW = 6;
  localparam int IW = 24;

  logic          clk = 1'b0;
  logic          reset = 1'b0;
  logic          start = 1'b0, stall = 1'b0, branch = 1'b0, jump = 1'b0;
  logic [AW-1:0] branch_offset = '0, jump_addr = '0;
`ifdef PC_LINK_EN
  logic          call = 1'b0, ret = 1'b0;
`endif
  logic [IW-1:0] instruction;
  logic [AW-1:0] address;
  logic [IW-1:0] instr;
  logic          instr_valid, halted;

  // program_memory model: combinational read
  logic [IW-1:0] mem [0:(1<<AW)-1];
  assign instruction = mem[address];

  typedef struct {
    logic [AW-1:0] addr;
    logic [IW-1:0] word;
  } fetch_t;
  fetch_t exp_q[$];

  int n_checks = 0;
  int n_fail   = 0;

  always #5 clk = ~clk;

  pc_sequencer #(.AddrSz(AW), .InstructionSz(IW)) dut (
    .clk           (clk),
    .reset         (reset),
    .start         (start),
    .stall         (stall),
    .branch        (branch),
    .branch_offset (branch_offset),
    .jump          (jump),
    .jump_addr     (jump_addr),
`ifdef PC_LINK_EN
    .call          (call),
    .ret           (ret),
`endif
    .instruction   (instruction),
    .address       (address),
    .instr         (instr),
    .instr_valid   (instr_valid),
    .halted        (halted)
  );

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end else begin
      $display("ok   %s: %0h", name, act);
    end
  endtask

  // Monitor: one transaction per valid fetch.
  always @(negedge clk) begin
    if (!reset && instr_valid) begin
      n_checks++;
      if (exp_q.size() == 0) begin
        n_fail++;
        $display("FAIL fetch: unexpected valid at address %0d", address);
      end else begin
        fetch_t e;
        e = exp_q.pop_front();
        if (address !== e.addr || instr !== e.word) begin
          n_fail++;
          $display("FAIL fetch: got addr %0d instr %0h expected addr %0d instr %0h",
                   address, instr, e.addr, e.word);
        end else begin
          $display("fetch addr %0d instr %0h", address, instr);
        end
      end
    end
  end

  task automatic expect_fetch(input logic [AW-1:0] a);
    fetch_t e;
    e.addr = a;
    e.word = mem[a];
    exp_q.push_back(e);
  endtask

  // One RUN cycle: drive controls, register the expected fetch for this cycle
  // (address a) when valid is expected, then advance to 1 ns after the edge.
  task automatic step(input logic st, input logic br, input logic [AW-1:0] off,
                      input logic jp, input logic [AW-1:0] ja,
                      input logic exp_valid, input logic [AW-1:0] a);
    stall = st; branch = br; branch_offset = off; jump = jp; jump_addr = ja;
    if (exp_valid) expect_fetch(a);
    @(posedge clk); #1;
    stall = 1'b0; branch = 1'b0; jump = 1'b0;
  endtask

  task automatic do_reset();
    reset = 1'b1;
    #3;
    reset = 1'b0;
    @(posedge clk); #1;
  endtask

  task automatic pulse_start();
    start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
  endtask

  initial begin
    for (int i = 0; i < (1 << AW); i++) mem[i] = {6'h00, 12'h5A0, 6'(i)};
    @(posedge clk); #1;

    // 1: reset state, then sequential fetch 0..4
    do_reset();
    check("reset_address", 32'(address), 32'd0);
    check("reset_valid", 32'(instr_valid), 32'd0);
    check("reset_instr", 32'(instr), 32'd0);
    check("reset_halted", 32'(halted), 32'd0);
    @(posedge clk); #1;
    check("idle_address_hold", 32'(address), 32'd0);
    pulse_start();
    for (int i = 0; i < 5; i++) step(0, 0, '0, 0, '0, 1, 6'(i));
    check("after_incr_pc", 32'(address), 32'd5);

    // 3: jump beats branch, then stall holds PC
    step(0, 1, 6'd2, 1, 6'd40, 1, 6'd5);
    check("jump_over_branch", 32'(address), 32'd40);
    for (int i = 0; i < 3; i++) begin
      stall = 1'b1; jump = 1'b1; jump_addr = 6'd12;
      #1;
      check("stall_valid", 32'(instr_valid), 32'd0);
      check("stall_instr", 32'(instr), 32'd0);
      @(posedge clk); #1;
      check("stall_pc", 32'(address), 32'd40);
    end
    stall = 1'b0; jump = 1'b0;
    step(0, 0, '0, 0, '0, 1, 6'd40);

    // 2: branch backwards and wrap both ways
    step(0, 0, '0, 1, 6'd10, 1, 6'd41);
    step(0, 1, 6'h3D, 0, '0, 1, 6'd10);
    check("branch_minus3", 32'(address), 32'd7);
    step(0, 0, '0, 1, 6'd0, 1, 6'd7);
    step(0, 1, 6'h3F, 0, '0, 1, 6'd0);
    check("branch_wrap_low", 32'(address), 32'd63);
    step(0, 0, '0, 0, '0, 1, 6'd63);
    check("incr_wrap_high", 32'(address), 32'd0);

    // 5: asynchronous reset mid-cycle at PC=20
    step(0, 0, '0, 1, 6'd20, 1, 6'd0);
    check("pre_async_pc", 32'(address), 32'd20);
    #2;
    reset = 1'b1;
    #1;
    check("async_reset_address", 32'(address), 32'd0);
    check("async_reset_valid", 32'(instr_valid), 32'd0);
    #3;
    reset = 1'b0;
    @(posedge clk); #1;
    check("idle_after_async", 32'(address), 32'd0);
    check("idle_valid_after_async", 32'(instr_valid), 32'd0);

    // 4: halt opcode at address 3
    mem[3] = {6'h3F, 18'h00123};
    pulse_start();
    for (int i = 0; i < 4; i++) step(0, 0, '0, 0, '0, 1, 6'(i));
    check("halted_flag", 32'(halted), 32'd1);
    check("halted_pc", 32'(address), 32'd3);
    check("halted_valid", 32'(instr_valid), 32'd0);
    pulse_start();
    step(0, 0, '0, 1, 6'd50, 0, '0);
    check("halted_after_start_pc", 32'(address), 32'd3);
    check("halted_after_start_flag", 32'(halted), 32'd1);
    do_reset();
    check("halt_reset_pc", 32'(address), 32'd0);
    check("halt_reset_flag", 32'(halted), 32'd0);
    mem[3] = {6'h00, 12'h5A0, 6'd3};

`ifdef PC_LINK_EN
    // 6: call / return through the link register
    pulse_start();
    step(0, 0, '0, 1, 6'd8, 1, 6'd0);
    call = 1'b1;
    step(0, 0, '0, 0, 6'd30, 1, 6'd8);
    call = 1'b0;
    check("call_target", 32'(address), 32'd30);
    step(0, 0, '0, 0, '0, 1, 6'd30);
    step(0, 0, '0, 0, '0, 1, 6'd31);
    ret = 1'b1;
    step(0, 0, '0, 1, 6'd44, 1, 6'd32);
    ret = 1'b0;
    check("ret_target", 32'(address), 32'd9);
`endif

    @(negedge clk);
    check("scoreboard_drained", 32'(exp_q.size()), 32'd0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #20000;
    $display("FAIL timeout: bench did not finish");
    $fatal(1, "timeout");
  end

endmodule
